// File: rtl/rst_seq_if.sv
// Reset-sequencer signal bundle: asynchronous reset sources in, SoC reset and status out.
interface rst_seq_if;
  logic       pll_locked_i;
  logic       btn_rst_i;
  logic       sw_rst_req_i;
  logic       sys_arst_o;
  logic [1:0] rst_cause_o;
  logic       run_o;

  modport master (
    output pll_locked_i,
    output btn_rst_i,
    output sw_rst_req_i,
    input  sys_arst_o,
    input  rst_cause_o,
    input  run_o
  );

  modport slave (
    input  pll_locked_i,
    input  btn_rst_i,
    input  sw_rst_req_i,
    output sys_arst_o,
    output rst_cause_o,
    output run_o
  );
endinterface

// File: rtl/rst_seq.sv
// SoC reset sequencer: waits for PLL lock, stretches reset release, and restarts on
// lock loss, a debounced push-button or a software request, recording the cause.
module rst_seq #(
  parameter int unsigned STRETCH_CYCLES  = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic      clk_i,
  input  logic      arst_n_i,
  rst_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    STRETCH   = 2'b01,
    RUN       = 2'b10,
    BTN_HOLD  = 2'b11
  } state_e;

  localparam logic [15:0] STRETCH_LAST = 16'(STRETCH_CYCLES - 1);
  // One bit wider than 20 so the full debounce range up to 2^20 is representable.
  localparam logic [20:0] DB_MAX       = 21'(DEBOUNCE_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [20:0] db_q, db_d;
  logic [1:0]  cause_q, cause_d;
  logic        lock_meta_q, lock_sync_q;
  logic        btn_meta_q, btn_sync_q;
  logic        sys_arst_q, run_q;
  logic        btn_stable_s;

  assign btn_stable_s = (db_q == DB_MAX);

  // Debounce counter: counts while the synchronized button is held, saturating.
  always_comb begin
    db_d = db_q;
    if (!btn_sync_q) begin
      db_d = 21'd0;
    end else if (db_q != DB_MAX) begin
      db_d = db_q + 21'd1;
    end else begin
      db_d = db_q;
    end
  end

  // Sequencer next-state, stretch counter and reset-cause logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = 16'd0;
        if (lock_sync_q) state_d = STRETCH;
        else             state_d = WAIT_LOCK;
      end
      STRETCH: begin
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (cnt_q == STRETCH_LAST) begin
          state_d = RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      RUN: begin
        cnt_d = 16'd0;
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
          cause_d = 2'd1;
        end else if (btn_stable_s) begin
          state_d = BTN_HOLD;
          cause_d = 2'd2;
        end else if (bus.sw_rst_req_i) begin
          state_d = STRETCH;
          cause_d = 2'd3;
        end else begin
          state_d = RUN;
        end
      end
      BTN_HOLD: begin
        cnt_d = 16'd0;
        if (!lock_sync_q)       state_d = WAIT_LOCK;
        else if (!btn_stable_s) state_d = STRETCH;
        else                    state_d = BTN_HOLD;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // State, counters, synchronizers and registered outputs.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= 16'd0;
      db_q        <= 21'd0;
      cause_q     <= 2'd0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      sys_arst_q  <= 1'b1;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      db_q        <= db_d;
      cause_q     <= cause_d;
      lock_meta_q <= bus.pll_locked_i;
      lock_sync_q <= lock_meta_q;
      btn_meta_q  <= bus.btn_rst_i;
      btn_sync_q  <= btn_meta_q;
      // Taken from the next state so reset drops on the very edge RUN is entered.
      sys_arst_q  <= (state_d != RUN);
      run_q       <= (state_d == RUN);
    end
  end

  assign bus.sys_arst_o  = sys_arst_q;
  assign bus.run_o       = run_q;
  assign bus.rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with STRETCH_CYCLES = 16 and DEBOUNCE_CYCLES = 8.
module tb_rst_seq;

  logic clk;
  logic arst_n;
  int   checks = 0;
  int   errors = 0;

  rst_seq_if bus ();

  rst_seq #(
    .STRETCH_CYCLES  (16),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until sys_arst_o reaches val; n = -1 when the budget expires.
  task automatic wait_sys(input logic val, input int maxc, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      if (!found) begin
        tick();
        if (bus.sys_arst_o === val) begin
          found = 1'b1;
          n = i;
        end
      end
    end
  endtask

  task automatic test_reset();
    int n;
    arst_n = 1'b0;
    bus.pll_locked_i = 1'b0;
    bus.btn_rst_i    = 1'b0;
    bus.sw_rst_req_i = 1'b0;
    repeat (3) tick();
    checks++; if (bus.sys_arst_o !== 1'b1) begin errors++; $display("FAIL reset_sys_arst: got %b want 1", bus.sys_arst_o); end
    checks++; if (bus.run_o !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", bus.run_o); end
    checks++; if (bus.rst_cause_o !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", bus.rst_cause_o); end
    arst_n = 1'b1;
    repeat (9) tick();
    bus.pll_locked_i = 1'b1;
    wait_sys(1'b0, 40, n);
    checks++; if (9 + n !== 28) begin errors++; $display("FAIL poweron_release_cycle: got %0d want 28", 9 + n); end
    checks++; if (bus.rst_cause_o !== 2'd0) begin errors++; $display("FAIL poweron_cause: got %0d want 0", bus.rst_cause_o); end
    checks++; if (bus.run_o !== 1'b1) begin errors++; $display("FAIL poweron_run: got %b want 1", bus.run_o); end
  endtask

  task automatic test_lock_loss();
    int n;
    tick();
    bus.pll_locked_i = 1'b0;
    wait_sys(1'b1, 10, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL lockloss_latency: got %0d want 3", n); end
    checks++; if (bus.rst_cause_o !== 2'd1) begin errors++; $display("FAIL lockloss_cause: got %0d want 1", bus.rst_cause_o); end
    bus.pll_locked_i = 1'b1;
    wait_sys(1'b0, 40, n);
    checks++; if (n !== 19) begin errors++; $display("FAIL lockloss_restretch: got %0d want 19", n); end
    checks++; if (bus.rst_cause_o !== 2'd1) begin errors++; $display("FAIL lockloss_cause_hold: got %0d want 1", bus.rst_cause_o); end
  endtask

  task automatic test_button();
    int n;
    bit saw_rst;
    saw_rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      bus.btn_rst_i = 1'b1;
      for (int k = 0; k < 5; k++) begin tick(); if (bus.sys_arst_o !== 1'b0) saw_rst = 1'b1; end
      bus.btn_rst_i = 1'b0;
      for (int k = 0; k < 5; k++) begin tick(); if (bus.sys_arst_o !== 1'b0) saw_rst = 1'b1; end
    end
    checks++; if (saw_rst !== 1'b0) begin errors++; $display("FAIL btn_bounce_no_reset: got %b want 0", saw_rst); end
    bus.btn_rst_i = 1'b1;
    wait_sys(1'b1, 20, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL btn_hold_latency: got %0d want 11", n); end
    repeat (9) tick();
    checks++; if (bus.sys_arst_o !== 1'b1) begin errors++; $display("FAIL btn_hold_sys_arst: got %b want 1", bus.sys_arst_o); end
    checks++; if (bus.rst_cause_o !== 2'd2) begin errors++; $display("FAIL btn_cause: got %0d want 2", bus.rst_cause_o); end
    checks++; if (bus.run_o !== 1'b0) begin errors++; $display("FAIL btn_hold_run: got %b want 0", bus.run_o); end
    bus.btn_rst_i = 1'b0;
    wait_sys(1'b0, 40, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL btn_release_latency: got %0d want 20", n); end
    checks++; if (bus.rst_cause_o !== 2'd2) begin errors++; $display("FAIL btn_cause_hold: got %0d want 2", bus.rst_cause_o); end
  endtask

  task automatic test_sw_req();
    int n;
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    checks++; if (bus.sys_arst_o !== 1'b1) begin errors++; $display("FAIL sw_sys_arst: got %b want 1", bus.sys_arst_o); end
    checks++; if (bus.rst_cause_o !== 2'd3) begin errors++; $display("FAIL sw_cause: got %0d want 3", bus.rst_cause_o); end
    checks++; if (bus.run_o !== 1'b0) begin errors++; $display("FAIL sw_run: got %b want 0", bus.run_o); end
    repeat (4) tick();
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    wait_sys(1'b0, 30, n);
    checks++; if (5 + n !== 16) begin errors++; $display("FAIL sw_stretch_len: got %0d want 16", 5 + n); end
    checks++; if (bus.rst_cause_o !== 2'd3) begin errors++; $display("FAIL sw_cause_hold: got %0d want 3", bus.rst_cause_o); end
  endtask

  task automatic test_simultaneous();
    int n;
    bus.btn_rst_i = 1'b1;
    repeat (8) tick();
    bus.pll_locked_i = 1'b0;
    repeat (2) tick();
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    checks++; if (bus.rst_cause_o !== 2'd1) begin errors++; $display("FAIL sim_all_cause: got %0d want 1", bus.rst_cause_o); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL sim_all_state: got %0d want 0", dut.state_q); end
    checks++; if (bus.sys_arst_o !== 1'b1) begin errors++; $display("FAIL sim_all_sys_arst: got %b want 1", bus.sys_arst_o); end
    bus.btn_rst_i = 1'b0;
    bus.pll_locked_i = 1'b1;
    wait_sys(1'b0, 60, n);
    checks++; if (n === -1) begin errors++; $display("FAIL sim_recover1: got timeout want RUN"); end
    bus.btn_rst_i = 1'b1;
    repeat (10) tick();
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    checks++; if (bus.rst_cause_o !== 2'd2) begin errors++; $display("FAIL sim_btn_sw_cause: got %0d want 2", bus.rst_cause_o); end
    checks++; if (bus.sys_arst_o !== 1'b1) begin errors++; $display("FAIL sim_btn_sw_sys_arst: got %b want 1", bus.sys_arst_o); end
    bus.btn_rst_i = 1'b0;
    wait_sys(1'b0, 60, n);
    checks++; if (n === -1) begin errors++; $display("FAIL sim_recover2: got timeout want RUN"); end
  endtask

  task automatic test_arst_mid_stretch();
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    repeat (7) tick();
    checks++; if (dut.cnt_q !== 16'd7) begin errors++; $display("FAIL arst_pre_count: got %0d want 7", dut.cnt_q); end
    arst_n = 1'b0;
    #1;
    checks++; if (bus.sys_arst_o !== 1'b1) begin errors++; $display("FAIL arst_sys_arst: got %b want 1", bus.sys_arst_o); end
    checks++; if (dut.cnt_q !== 16'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", dut.cnt_q); end
    checks++; if (bus.rst_cause_o !== 2'd0) begin errors++; $display("FAIL arst_cause: got %0d want 0", bus.rst_cause_o); end
    checks++; if (bus.run_o !== 1'b0) begin errors++; $display("FAIL arst_run: got %b want 0", bus.run_o); end
    tick();
    arst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock_loss();
    test_button();
    test_sw_req();
    test_simultaneous();
    test_arst_mid_stretch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
